// File: rtl/bp_pkg.sv
// Shared definitions for the backprop sequencers.
//   state_t          : 3-bit controller state encoding
//   DWIDTH_DEF       : default data word width
//   SAT_MAX/SAT_MIN  : signed saturation limits at the default width
package bp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_T = 3'd2,
        CAPT = 3'd3,
        CALC = 3'd4,
        WR   = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam int DWIDTH_DEF = 32;

    localparam logic [DWIDTH_DEF-1:0] SAT_MAX = {1'b0, {(DWIDTH_DEF-1){1'b1}}};
    localparam logic [DWIDTH_DEF-1:0] SAT_MIN = {1'b1, {(DWIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/sat_accumulate.sv
// Signed saturating adder.
//   acc, add : W-bit signed operands
//   sum      : acc+add clamped to the W-bit signed range
//   ovf      : high when the clamp was applied
module sat_accumulate #(
    parameter int W = 32
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] add,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] ext;

    assign ext = {acc[W-1], acc} + {add[W-1], add};

    // The top two bits of the W+1-bit sum disagree exactly when the result
    // does not fit in W bits; the top bit gives the direction.
    always_comb begin
        sum = ext[W-1:0];
        ovf = 1'b0;
        if (ext[W] != ext[W-1]) begin
            ovf = 1'b1;
            sum = ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/delta3_sequencer.sv
// Output-layer delta/cost sequencer. Walks k = 0..OutNeuron-1, reading a3[k]
// and t[k] from BRAM, strobing the delta3 datapath, writing delta3[k] back
// and accumulating a saturating total cost.
//   start/busy/done          : handshake with the training FSM
//   bram_addr/rd_en/wr_en/din: shared BRAM port (read data one cycle later)
//   bram_dout                : BRAM read data
//   a3, t                    : registered operands to the datapath
//   en_delta3, en_cost       : datapath register enables
//   delta3, cost             : datapath results
//   cost_sum, cost_ovf       : run total and sticky saturation flag
module delta3_sequencer
    import bp_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 10,
    parameter int OutNeuron = 16,
    parameter int A3_BASE   = 0,
    parameter int T_BASE    = 16,
    parameter int D3_BASE   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] bram_addr,
    output logic              bram_rd_en,
    input  logic [DWIDTH-1:0] bram_dout,
    output logic              bram_wr_en,
    output logic [DWIDTH-1:0] bram_din,
    output logic [DWIDTH-1:0] a3,
    output logic [DWIDTH-1:0] t,
    output logic              en_delta3,
    output logic              en_cost,
    input  logic [DWIDTH-1:0] delta3,
    input  logic [DWIDTH-1:0] cost,
    output logic [DWIDTH-1:0] cost_sum,
    output logic              cost_ovf
);

    localparam int            KW     = (OutNeuron > 1) ? $clog2(OutNeuron) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(OutNeuron - 1);

    state_t            state, nxt;
    logic [KW-1:0]     k;
    logic [DWIDTH-1:0] sum_nxt;
    logic              ovf_nxt;

    sat_accumulate #(.W(DWIDTH)) u_sat (
        .acc (cost_sum),
        .add (cost),
        .sum (sum_nxt),
        .ovf (ovf_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            a3       <= '0;
            t        <= '0;
            cost_sum <= '0;
            cost_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    k        <= '0;
                    cost_sum <= '0;
                    cost_ovf <= 1'b0;
                end
                RD_T: a3 <= bram_dout;   // a3 read issued in RD_A lands now
                CAPT: t  <= bram_dout;   // target read issued in RD_T lands now
                WR: begin
                    cost_sum <= sum_nxt;
                    if (ovf_nxt) cost_ovf <= 1'b1;
                    if (k != K_LAST) k <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt        = state;
        busy       = 1'b1;
        done       = 1'b0;
        bram_addr  = '0;
        bram_rd_en = 1'b0;
        bram_wr_en = 1'b0;
        bram_din   = '0;
        en_delta3  = 1'b0;
        en_cost    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) nxt = RD_A;
            end
            RD_A: begin
                bram_addr  = AWIDTH'(A3_BASE) + AWIDTH'(k);
                bram_rd_en = 1'b1;
                nxt        = RD_T;
            end
            RD_T: begin
                bram_addr  = AWIDTH'(T_BASE) + AWIDTH'(k);
                bram_rd_en = 1'b1;
                nxt        = CAPT;
            end
            CAPT: nxt = CALC;
            CALC: begin
                en_delta3 = 1'b1;
                en_cost   = 1'b1;
                nxt       = WR;
            end
            WR: begin
                bram_addr  = AWIDTH'(D3_BASE) + AWIDTH'(k);
                bram_wr_en = 1'b1;
                bram_din   = delta3;
                nxt        = (k == K_LAST) ? DONE : RD_A;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: begin
                busy = 1'b0;
                nxt  = IDLE;
            end
        endcase
    end

endmodule

// File: doc/delta3_sequencer.md
Name: delta3_sequencer

Overview:
- Controller that sequences the output-layer delta/cost datapath across all output neurons during backpropagation.
- Per neuron: fetches a3[k] and target t[k] from shared BRAM, presents them to the datapath, pulses en_delta3/en_cost, writes delta3[k] back to BRAM, and accumulates total cost with saturation.
- Sits between the training top-level FSM (start/done handshake) and the delta3 datapath plus BRAM port.

Parameters:
- DWIDTH, 32, data word width (signed fixed point).
- AWIDTH, 10, BRAM address width.
- OutNeuron, 16, number of output neurons processed per run (>=1).
- A3_BASE, 0, BRAM base address of a3 vector.
- T_BASE, 16, BRAM base address of target vector.
- D3_BASE, 32, BRAM base address for delta3 write-back.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from first cycle after accepted start through the DONE cycle.
- done  out  1  one-cycle pulse at completion.
- bram_addr  out  AWIDTH  read/write address.
- bram_rd_en  out  1  read strobe; data returns one cycle later.
- bram_dout  in  DWIDTH  BRAM read data.
- bram_wr_en  out  1  write strobe.
- bram_din  out  DWIDTH  write data (= delta3).
- a3  out  DWIDTH  registered a3 to datapath.
- t  out  DWIDTH  registered target to datapath.
- en_delta3  out  1  datapath delta3 register enable.
- en_cost  out  1  datapath cost register enable.
- delta3  in  DWIDTH  datapath registered delta3.
- cost  in  DWIDTH  datapath registered squared error.
- cost_sum  out  DWIDTH  saturating signed sum of cost over the run.
- cost_ovf  out  1  sticky: saturation occurred this run.

Behaviour:
- Reset values (async, rst_n=0): state IDLE, k=0. All outputs 0: busy, done, bram_rd_en, bram_wr_en, bram_addr, bram_din, a3, t, en_delta3, en_cost, cost_sum, cost_ovf.
- States:
  - IDLE: waits for start. On start, clear cost_sum and cost_ovf, set k=0, go to RD_A.
  - RD_A: bram_addr=A3_BASE+k, bram_rd_en=1. Next: RD_T.
  - RD_T: bram_addr=T_BASE+k, bram_rd_en=1, a3<=bram_dout. Next: CAPT.
  - CAPT: t<=bram_dout. Next: CALC.
  - CALC: en_delta3=1, en_cost=1 (datapath latches at end of cycle). Next: WR.
  - WR: bram_wr_en=1, bram_addr=D3_BASE+k, bram_din=delta3, cost_sum<=sat(cost_sum+cost). If k==OutNeuron-1, go to DONE; else k<=k+1 and go to RD_A.
  - DONE: done=1. Next: IDLE.
- Strobes (rd_en, wr_en, en_*) are combinational from state and high only in their listed state. bram_addr is 0 in IDLE, CAPT, CALC and DONE.
- Latency: start seen at edge 0 means RD_A occupies cycle 1. Each neuron takes 5 cycles. done is high in cycle 5*OutNeuron+1. busy is high in cycles 1..5*OutNeuron+1.
- Saturation: compute a DWIDTH+1-bit signed sum.
  - Above 2^(DWIDTH-1)-1: clamp to max positive, set cost_ovf.
  - Below -2^(DWIDTH-1): clamp to max negative, set cost_ovf.
  - cost_ovf stays set until the next accepted start.
- start while not IDLE (including DONE): ignored, no queuing.
- start asserted in the cycle after DONE: accepted normally, so back-to-back runs are allowed.
- cost_sum, a3 and t hold their values after done until the next start.
- k is exactly clog2(OutNeuron) bits wide (minimum 1) and never wraps past OutNeuron-1.
- Reset mid-run: immediate return to IDLE with reset values. No partial write completes after rst_n falls.

Decomposition:
- Shared package (bp_pkg): state encoding localparams (IDLE, RD_A, RD_T, CAPT, CALC, WR, DONE; 3-bit) and the DWIDTH-derived saturation limits SAT_MAX/SAT_MIN.
- One sub-module: sat_accumulate (signed saturating adder with overflow flag), reusable by the hidden-layer cost path.

Test Plan:
- OutNeuron=4; BRAM a3={10,20,30,40}, t={1,2,3,4}; stub datapath delta3=a3-t, cost=5 -> writes 9,18,27,36 to addresses 32..35; cost_sum=20; done in cycle 21 after start; cost_ovf=0.
- Address/strobe trace for neuron 0 -> rd at addr 0 (cycle 1), rd at 16 (cycle 2), en_delta3/en_cost high in cycle 4 only, wr at 32 in cycle 5.
- Stub cost=0x4000_0000 with OutNeuron=4 -> cost_sum saturates to 0x7FFF_FFFF at the second add; cost_ovf=1 and stays 1; next start clears both.
- start pulsed during RD_T and during DONE -> ignored, exactly one run. start in the cycle after DONE -> second run begins with cost_sum cleared.
- rst_n low during CALC of neuron 2 -> all outputs 0 immediately, no write to addr 34; a subsequent start runs a full sequence from k=0.
- OutNeuron=1 -> single 5-cycle neuron pass, done in cycle 6, busy high in cycles 1..6.
